// File: rtl/pet_memmap_if.sv
// Bus bundle between the CPU side, the RAM/VRAM/IO/ROM blocks and the DMA
// injector of the PET memory-map controller.
//
// DMA handshake: the requester raises dma_req with dma_we/dma_addr/dma_din
// stable and holds them until it sees dma_ack. dma_ack is a one-clock pulse
// that marks completion. For reads, dma_dout is valid in that same clock.
// The requester drops dma_req in the ack clock; a request still high after
// the ack clock is treated as a new request.
interface pet_memmap_if #(
  parameter int RAM_AW = 17
);
  logic              ce_1m;
  logic [15:0]       addr;
  logic [7:0]        data_in;
  logic              we;
  logic [7:0]        data_out;
  logic [7:0]        rom_data;
  logic [7:0]        vram_q;
  logic [7:0]        io_q;
  logic              vram_we;
  logic              io_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [7:0]        ram_din;
  logic              ram_we;
  logic [7:0]        ram_q;
  logic              dma_req;
  logic              dma_we;
  logic [RAM_AW-1:0] dma_addr;
  logic [7:0]        dma_din;
  logic [7:0]        dma_dout;
  logic              dma_ack;
  logic [7:0]        exp_ctrl;
  logic [1:0]        dma_state;   // debug view of the DMA FSM state

  modport slave (
    input  ce_1m, addr, data_in, we, rom_data, vram_q, io_q, ram_q,
           dma_req, dma_we, dma_addr, dma_din,
    output data_out, vram_we, io_we, ram_addr, ram_din, ram_we,
           dma_dout, dma_ack, exp_ctrl, dma_state
  );

  modport master (
    output ce_1m, addr, data_in, we, rom_data, vram_q, io_q, ram_q,
           dma_req, dma_we, dma_addr, dma_din,
    input  data_out, vram_we, io_we, ram_addr, ram_din, ram_we,
           dma_dout, dma_ack, exp_ctrl, dma_state
  );
endinterface

// File: rtl/pet_memmap_ctl.sv
// PET memory-map controller: CPU address decode (base RAM, 8096-style banked
// expansion RAM, VRAM, I/O, ROM) and arbitration of the single-port main RAM
// between the CPU and a DMA / program-injection port. The CPU always wins.
module pet_memmap_ctl #(
  parameter int BASE_KB = 32,
  parameter int EXP_EN  = 1,
  parameter int VRAM_KB = 2,
  parameter int RAM_AW  = 15 + 2*EXP_EN
) (
  input logic         clk,
  input logic         reset,
  pet_memmap_if.slave bus
);
  typedef enum logic [1:0] {
    DMA_IDLE   = 2'd0,
    DMA_ACCESS = 2'd1,
    DMA_ACK    = 2'd2
  } dma_state_t;

  typedef enum logic [2:0] {
    RG_NONE = 3'd0,
    RG_RAM  = 3'd1,
    RG_EXP  = 3'd2,
    RG_VRAM = 3'd3,
    RG_IO   = 3'd4,
    RG_ROM  = 3'd5
  } region_t;

  // A 2K screen mirrors through the full 4K window; larger screens widen it.
  localparam int         VRAM_WIN_KB = (VRAM_KB < 4) ? 4 : VRAM_KB;
  localparam logic [16:0] VRAM_END   = 17'h08000 + 17'(VRAM_WIN_KB * 1024);
  localparam logic [16:0] BASE_END   = 17'(BASE_KB * 1024);

  logic [7:0]        r_exp_ctrl;
  region_t           r_rd_region;
  logic              r_rd_pending;
  logic [7:0]        r_data_out;
  dma_state_t        r_dma_state;
  logic              r_dma_ack;
  logic              r_dma_we;
  logic [RAM_AW-1:0] r_dma_addr;
  logic [7:0]        r_dma_din;

  region_t     w_region;
  logic        w_exp_on;
  logic        w_is_vram;
  logic        w_is_io;
  logic        w_is_ctrl;
  logic        w_wprot;
  logic [1:0]  w_block;
  logic [16:0] w_cpu_addr17;
  logic        w_cpu_wr;
  logic        w_dma_owns;

  // Address decode of the current CPU address under the live control register.
  always_comb begin
    w_exp_on     = (EXP_EN != 0) && r_exp_ctrl[7];
    w_is_vram    = bus.addr[15] && ({1'b0, bus.addr} < VRAM_END);
    w_is_io      = (bus.addr[15:11] == 5'b11101);
    w_is_ctrl    = (EXP_EN != 0) && (bus.addr == 16'hFFF0);
    w_block      = bus.addr[14] ? {r_exp_ctrl[3], 1'b1} : {r_exp_ctrl[2], 1'b0};
    w_wprot      = bus.addr[14] ? r_exp_ctrl[1] : r_exp_ctrl[0];
    w_region     = RG_ROM;
    if (!bus.addr[15]) begin
      w_region = ({1'b0, bus.addr} < BASE_END) ? RG_RAM : RG_NONE;
    end else if (w_exp_on) begin
      if (w_is_vram && r_exp_ctrl[5])    w_region = RG_VRAM;
      else if (w_is_io && r_exp_ctrl[6]) w_region = RG_IO;
      else                               w_region = RG_EXP;
    end else if (w_is_vram) begin
      w_region = RG_VRAM;
    end else if (w_is_io) begin
      w_region = RG_IO;
    end
    // Expansion blocks sit above the 32K base: 32K + block*16K + offset.
    w_cpu_addr17 = (w_region == RG_EXP)
                 ? 17'h08000 + {1'b0, w_block, 14'h0000} + {3'b000, bus.addr[13:0]}
                 : {2'b00, bus.addr[14:0]};
  end

  // Single-clock write strobes and RAM port mux; the CPU strobe has priority.
  always_comb begin
    w_cpu_wr     = bus.ce_1m && bus.we && !reset;
    w_dma_owns   = (r_dma_state == DMA_ACCESS) && !bus.ce_1m;
    bus.vram_we  = w_cpu_wr && (w_region == RG_VRAM);
    bus.io_we    = w_cpu_wr && (w_region == RG_IO);
    bus.ram_we   = (w_cpu_wr && !w_is_ctrl &&
                    ((w_region == RG_RAM) || ((w_region == RG_EXP) && !w_wprot)))
                 || (w_dma_owns && r_dma_we && !reset);
    bus.ram_addr = w_dma_owns ? r_dma_addr : RAM_AW'(w_cpu_addr17);
    bus.ram_din  = w_dma_owns ? r_dma_din : bus.data_in;
  end

  // Control register load and CPU read-data capture one clock after ce_1m.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_exp_ctrl   <= 8'h00;
      r_rd_region  <= RG_NONE;
      r_rd_pending <= 1'b0;
      r_data_out   <= 8'h00;
    end else begin
      if (w_cpu_wr && w_is_ctrl) r_exp_ctrl <= bus.data_in;
      r_rd_pending <= bus.ce_1m;
      if (bus.ce_1m) r_rd_region <= w_region;
      if (r_rd_pending) begin
        case (r_rd_region)
          RG_RAM, RG_EXP: r_data_out <= bus.ram_q;
          RG_VRAM:        r_data_out <= bus.vram_q;
          RG_IO:          r_data_out <= bus.io_q;
          RG_ROM:         r_data_out <= bus.rom_data;
          default:        r_data_out <= 8'hFF;
        endcase
      end
    end
  end

  // DMA FSM: start only in a clock the CPU leaves the RAM port free.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dma_state <= DMA_IDLE;
      r_dma_ack   <= 1'b0;
      r_dma_we    <= 1'b0;
      r_dma_addr  <= '0;
      r_dma_din   <= 8'h00;
    end else begin
      r_dma_ack <= 1'b0;
      case (r_dma_state)
        DMA_IDLE: begin
          if (bus.dma_req && !bus.ce_1m) begin
            r_dma_we    <= bus.dma_we;
            r_dma_addr  <= bus.dma_addr;
            r_dma_din   <= bus.dma_din;
            r_dma_state <= DMA_ACCESS;
          end
        end
        DMA_ACCESS: begin
          r_dma_ack   <= 1'b1;
          r_dma_state <= DMA_ACK;
        end
        DMA_ACK:  r_dma_state <= DMA_IDLE;
        default:  r_dma_state <= DMA_IDLE;
      endcase
    end
  end

  assign bus.data_out  = r_data_out;
  assign bus.exp_ctrl  = r_exp_ctrl;
  assign bus.dma_ack   = r_dma_ack;
  assign bus.dma_dout  = bus.ram_q;
  assign bus.dma_state = r_dma_state;
endmodule

// File: tb/tb_pet_memmap_ctl.sv
// Bench for pet_memmap_ctl: directed scenarios followed by random CPU / DMA
// traffic, checked against a memory-map model derived from the address rules.
module tb_pet_memmap_ctl;
  localparam int AW      = 17;
  localparam int BASE_KB = 32;
  localparam int K_NONE = 0, K_RAM = 1, K_EXP = 2, K_VRAM = 3, K_IO = 4, K_ROM = 5, K_CTRL = 6;
  localparam int ST_IDLE = 0, ST_ACCESS = 1;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [7:0] ram_mem [0:(1<<AW)-1];   // the physical RAM attached to the DUT
  logic [7:0] ref_mem [0:(1<<AW)-1];   // expected RAM contents
  logic [7:0] ref_ctrl;
  logic [7:0] exp_q[$];                // expected CPU read data

  pet_memmap_if #(.RAM_AW(AW)) bus ();

  pet_memmap_ctl #(.BASE_KB(BASE_KB), .EXP_EN(1), .VRAM_KB(2), .RAM_AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset / environment ----------------
  always #5 clk = ~clk;

  // Synchronous single-port RAM, read-before-write.
  always @(posedge clk) begin
    if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_din;
    bus.ram_q <= ram_mem[bus.ram_addr];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // ---------------- reference model ----------------
  // Map a CPU address to a region and (for RAM) a physical address.
  task automatic ref_decode(input logic [15:0] a, output int kind, output int phys, output bit prot);
    int  blk;
    int  ai;
    bit  en;
    ai   = int'(a);
    en   = ref_ctrl[7];
    phys = 0;
    prot = 1'b0;
    if (ai < 32'h8000) begin
      kind = (ai < BASE_KB * 1024) ? K_RAM : K_NONE;
      phys = ai;
    end else if (en && ai < 32'h9000 && ref_ctrl[5]) begin
      kind = K_VRAM;
    end else if (en && ai >= 32'hE800 && ai < 32'hF000 && ref_ctrl[6]) begin
      kind = K_IO;
    end else if (en) begin
      if (ai < 32'hC000) begin
        blk  = int'(ref_ctrl[2]) * 2;
        prot = ref_ctrl[0];
      end else begin
        blk  = int'(ref_ctrl[3]) * 2 + 1;
        prot = ref_ctrl[1];
      end
      kind = K_EXP;
      phys = 32768 + blk * 16384 + (ai % 16384);
    end else if (ai < 32'h9000) begin
      kind = K_VRAM;
    end else if (ai >= 32'hE800 && ai < 32'hF000) begin
      kind = K_IO;
    end else begin
      kind = K_ROM;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    int kind, phys;
    bit prot, exp_ram;
    ref_decode(a, kind, phys, prot);
    if (a == 16'hFFF0) kind = K_CTRL;
    exp_ram = (kind == K_RAM) || (kind == K_EXP && !prot);
    @(negedge clk);
    bus.ce_1m = 1'b1; bus.we = 1'b1; bus.addr = a; bus.data_in = d;
    #1;
    check_eq("wr_ram_we", 32'(bus.ram_we), 32'(exp_ram));
    check_eq("wr_vram_we", 32'(bus.vram_we), 32'(kind == K_VRAM));
    check_eq("wr_io_we", 32'(bus.io_we), 32'(kind == K_IO));
    if (exp_ram) begin
      check_eq("wr_ram_addr", 32'(bus.ram_addr), phys);
      check_eq("wr_ram_din", 32'(bus.ram_din), 32'(d));
    end
    @(negedge clk);
    bus.ce_1m = 1'b0; bus.we = 1'b0;
    if (kind == K_CTRL) ref_ctrl = d;
    if (exp_ram) ref_mem[phys] = d;
    check_eq("exp_ctrl", 32'(bus.exp_ctrl), 32'(ref_ctrl));
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic cpu_read(input logic [15:0] a);
    int         kind, phys;
    bit         prot;
    logic [7:0] w;
    ref_decode(a, kind, phys, prot);
    bus.rom_data = 8'($urandom);
    bus.vram_q   = 8'($urandom);
    bus.io_q     = 8'($urandom);
    case (kind)
      K_RAM, K_EXP: w = ref_mem[phys];
      K_VRAM:       w = bus.vram_q;
      K_IO:         w = bus.io_q;
      K_ROM:        w = bus.rom_data;
      default:      w = 8'hFF;
    endcase
    exp_q.push_back(w);
    @(negedge clk);
    bus.ce_1m = 1'b1; bus.we = 1'b0; bus.addr = a;
    #1;
    check_eq("rd_no_strobe", {29'd0, bus.ram_we, bus.vram_we, bus.io_we}, 32'd0);
    @(negedge clk);
    bus.ce_1m = 1'b0;
    @(negedge clk);
    check_eq("rd_data", 32'(bus.data_out), 32'(exp_q.pop_front()));
    @(negedge clk);
    check_eq("rd_hold", 32'(bus.data_out), 32'(w));
  endtask

  // DMA transfer; optionally a CPU base-RAM write lands in the same clock.
  task automatic dma_op(input bit wr, input int pa, input logic [7:0] d,
                        input bit with_ce, input logic [15:0] ca, input logic [7:0] cd);
    int         lat;
    logic [7:0] want_q;
    @(negedge clk);
    bus.dma_req = 1'b1; bus.dma_we = wr; bus.dma_addr = AW'(pa); bus.dma_din = d;
    if (with_ce) begin
      bus.ce_1m = 1'b1; bus.we = 1'b1; bus.addr = ca; bus.data_in = cd;
      #1;
      check_eq("col_cpu_addr", 32'(bus.ram_addr), 32'(ca));
      check_eq("col_cpu_din", 32'(bus.ram_din), 32'(cd));
      ref_mem[int'(ca)] = cd;
    end
    want_q = ref_mem[pa];
    lat = 0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      bus.ce_1m = 1'b0; bus.we = 1'b0;
      if (bus.dma_ack) begin
        lat = n;
        break;
      end
    end
    check_eq("dma_ack_latency", lat, with_ce ? 3 : 2);
    if (!wr) check_eq("dma_dout", 32'(bus.dma_dout), 32'(want_q));
    bus.dma_req = 1'b0;
    if (wr) ref_mem[pa] = d;
    @(negedge clk);
    check_eq("dma_ack_pulse", 32'(bus.dma_ack), 32'd0);
    check_eq("dma_state_idle", 32'(bus.dma_state), ST_IDLE);
  endtask

  function automatic logic [15:0] rand_addr();
    case ($urandom_range(0, 5))
      0:       return 16'($urandom_range(16'h0000, 16'h7FFF));
      1:       return 16'($urandom_range(16'h8000, 16'h8FFF));
      2:       return 16'($urandom_range(16'h9000, 16'hBFFF));
      3:       return 16'($urandom_range(16'hC000, 16'hE7FF));
      4:       return 16'($urandom_range(16'hE800, 16'hEFFF));
      default: return ($urandom_range(0, 3) == 0) ? 16'hFFF0 : 16'($urandom_range(16'hF000, 16'hFFFF));
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] v;
    int         pa, old_v;
    logic [15:0] ca;

    for (int i = 0; i < (1 << AW); i++) begin
      v = 8'($urandom);
      ram_mem[i] = v;
      ref_mem[i] = v;
    end
    ref_ctrl    = 8'h00;
    reset       = 1'b1;
    bus.ce_1m   = 1'b0; bus.we = 1'b0; bus.addr = 16'h0000; bus.data_in = 8'h00;
    bus.rom_data = 8'h00; bus.vram_q = 8'h00; bus.io_q = 8'h00;
    bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = '0; bus.dma_din = 8'h00;
    repeat (3) @(negedge clk);
    check_eq("rst_data_out", 32'(bus.data_out), 32'h00);
    check_eq("rst_exp_ctrl", 32'(bus.exp_ctrl), 32'h00);
    check_eq("rst_dma_ack", 32'(bus.dma_ack), 32'd0);
    check_eq("rst_strobes", {29'd0, bus.ram_we, bus.vram_we, bus.io_we}, 32'd0);
    check_eq("rst_state", 32'(bus.dma_state), ST_IDLE);
    reset = 1'b0;

    // ROM behind the control register while expansion is off
    cpu_read(16'hFFF0);
    cpu_read(16'hFFF5);

    // expansion on, block 0 at $8000
    cpu_write(16'hFFF0, 8'h80);
    cpu_write(16'h8100, 8'h5A);
    check_eq("exp_ram_8100", 32'(ram_mem[32'h08100]), 32'h5A);
    cpu_read(16'h8100);

    // screen and I/O peek-through
    cpu_write(16'hFFF0, 8'hE0);
    cpu_write(16'h8100, 8'h33);
    cpu_write(16'hE810, 8'h44);
    cpu_read(16'hE810);

    // write protect both windows
    cpu_write(16'hFFF0, 8'h83);
    old_v = int'(ref_mem[32'h0C000]);
    cpu_write(16'hC000, 8'hA5);
    cpu_read(16'hC000);
    check_eq("wp_unchanged", 32'(ram_mem[32'h0C000]), old_v);

    // upper banks, unprotected
    cpu_write(16'hFFF0, 8'h8C);
    cpu_write(16'h9234, 8'h71);
    cpu_write(16'hD234, 8'h72);
    cpu_read(16'h9234);
    cpu_read(16'hD234);

    // DMA write coincident with CPU access, then readback through the CPU
    cpu_write(16'hFFF0, 8'h00);
    dma_op(1'b1, 32'h0400, 8'h11, 1'b1, 16'h1234, 8'h22);
    cpu_read(16'h0400);
    cpu_read(16'h1234);
    dma_op(1'b0, 32'h0400, 8'h00, 1'b0, 16'h0000, 8'h00);
    dma_op(1'b0, 32'h1ABCD, 8'h00, 1'b0, 16'h0000, 8'h00);

    // reset while the DMA FSM is in ACCESS
    cpu_write(16'hFFF0, 8'h80);
    pa    = 32'h0600;
    old_v = int'(ref_mem[pa]);
    @(negedge clk);
    bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = AW'(pa); bus.dma_din = ~ref_mem[pa];
    @(negedge clk);
    check_eq("rst_mid_state", 32'(bus.dma_state), ST_ACCESS);
    reset = 1'b1; bus.dma_req = 1'b0;
    #1;
    check_eq("rst_mid_ram_we", 32'(bus.ram_we), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    ref_ctrl = 8'h00;
    check_eq("rst_mid_ack", 32'(bus.dma_ack), 32'd0);
    check_eq("rst_mid_idle", 32'(bus.dma_state), ST_IDLE);
    check_eq("rst_mid_ctrl", 32'(bus.exp_ctrl), 32'h00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("rst_mid_no_ack", 32'(bus.dma_ack), 32'd0);
    end
    check_eq("rst_mid_mem", 32'(ram_mem[pa]), old_v);
    cpu_read(16'h0600);

    // random traffic
    for (int it = 0; it < 200; it++) begin
      case ($urandom_range(0, 9))
        0: cpu_write(16'hFFF0, {1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 4'($urandom)});
        1, 2, 3: cpu_write(rand_addr(), 8'($urandom));
        4, 5, 6: cpu_read(rand_addr());
        7, 8: dma_op(1'($urandom), $urandom_range(0, (1 << AW) - 1), 8'($urandom),
                     1'b0, 16'h0000, 8'h00);
        default: begin
          pa = $urandom_range(0, (1 << AW) - 1);
          ca = 16'($urandom_range(0, 16'h7FFF));
          if (int'(ca) == pa) ca = ca ^ 16'h0001;
          dma_op(1'($urandom), pa, 8'($urandom), 1'b1, ca, 8'($urandom));
        end
      endcase
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
